// File: rtl/lsu_queue.sv
// lsu_queue: in-order load/store request queue in front of a single-port data cache
module lsu_queue #(
  parameter int DEPTH  = 4,
  parameter int ROB_W  = 6,
  parameter int PREG_W = 6
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      flush,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [31:0]               in_addr,
  input  logic [31:0]               in_wdata,
  input  logic [1:0]                in_size,
  input  logic                      in_is_load,
  input  logic                      in_unsigned,
  input  logic [ROB_W-1:0]          in_rob_idx,
  input  logic [PREG_W-1:0]         in_rd_tag,
  input  logic                      in_rd_is_fp,
  output logic [$clog2(DEPTH):0]    occupancy,
  output logic                      dc_req,
  output logic                      dc_we,
  output logic [31:0]               dc_addr,
  output logic [31:0]               dc_wdata,
  output logic [3:0]                dc_wstrb,
  input  logic [31:0]               dc_rdata,
  input  logic                      dc_ack,
  output logic                      wb_valid,
  output logic [31:0]               wb_value,
  output logic [ROB_W-1:0]          wb_rob_idx,
  output logic [PREG_W-1:0]         wb_dest_tag,
  output logic                      wb_dest_is_fp,
  output logic                      wb_exception
);
  localparam int AW = $clog2(DEPTH);

  typedef struct packed {
    logic [31:0]       addr;
    logic [31:0]       wdata;
    logic [1:0]        size;
    logic              ld;
    logic              uns;
    logic [ROB_W-1:0]  rob;
    logic [PREG_W-1:0] tag;
    logic              fp;
  } ent_t;

  typedef enum logic [1:0] {IDLE, REQ, WB, DRAIN} st_t;

  st_t               r_st, w_nst;
  ent_t              r_q [DEPTH];
  ent_t              w_h;
  logic [AW-1:0]     r_wp, r_rp;
  logic [AW:0]       r_cnt;
  logic              w_push, w_pop, w_exc, w_go_req, w_go_exc, w_ack, w_done;
  logic [7:0]        w_b;
  logic [15:0]       w_hw;
  logic [31:0]       w_ldv;
  logic              r_dc_req, r_dc_we;
  logic [31:0]       r_dc_addr, r_dc_wdata;
  logic [3:0]        r_dc_wstrb;
  logic              r_wb_valid, r_wb_exc, r_wb_fp;
  logic [31:0]       r_wb_value;
  logic [ROB_W-1:0]  r_wb_rob;
  logic [PREG_W-1:0] r_wb_tag;

  assign w_h      = r_q[r_rp];
  assign in_ready = (r_cnt != (AW+1)'(DEPTH)) && (r_st != DRAIN);
  assign w_push   = in_valid && in_ready && !flush;
  assign w_exc    = (w_h.size == 2'd3) || (w_h.size == 2'd1 && w_h.addr[0]) ||
                    (w_h.size == 2'd2 && w_h.addr[1:0] != 2'b00);
  assign w_go_req = (r_st == IDLE) && !flush && (r_cnt != '0) && !w_exc;
  assign w_go_exc = (r_st == IDLE) && !flush && (r_cnt != '0) && w_exc;
  assign w_ack    = (r_st == REQ) && dc_ack && !flush;
  assign w_done   = (r_st == REQ || r_st == DRAIN) && dc_ack;
  assign w_pop    = w_go_exc || w_ack;
  assign w_b      = dc_rdata[{w_h.addr[1:0], 3'b000} +: 8];
  assign w_hw     = w_h.addr[1] ? dc_rdata[31:16] : dc_rdata[15:0];
  assign w_ldv    = (w_h.size == 2'd0) ? {{24{!w_h.uns && w_b[7]}}, w_b} :
                    (w_h.size == 2'd1) ? {{16{!w_h.uns && w_hw[15]}}, w_hw} : dc_rdata;

  assign occupancy     = r_cnt;
  assign dc_req        = r_dc_req;
  assign dc_we         = r_dc_we;
  assign dc_addr       = r_dc_addr;
  assign dc_wdata      = r_dc_wdata;
  assign dc_wstrb      = r_dc_wstrb;
  assign wb_valid      = r_wb_valid;
  assign wb_value      = r_wb_value;
  assign wb_rob_idx    = r_wb_rob;
  assign wb_dest_tag   = r_wb_tag;
  assign wb_dest_is_fp = r_wb_fp;
  assign wb_exception  = r_wb_exc;

  // next state; an ack arriving together with a flush retires the access immediately
  always_comb begin
    w_nst = r_st;
    case (r_st)
      IDLE:    w_nst = w_go_exc ? WB : w_go_req ? REQ : IDLE;
      REQ:     w_nst = flush ? (dc_ack ? IDLE : DRAIN) : dc_ack ? WB : REQ;
      WB:      w_nst = IDLE;
      DRAIN:   w_nst = dc_ack ? IDLE : DRAIN;
      default: w_nst = IDLE;
    endcase
  end

  // state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_st <= IDLE;
    else        r_st <= w_nst;

  // queue storage, no reset needed since validity lives in the pointers
  always_ff @(posedge clk)
    if (w_push) r_q[r_wp] <= '{in_addr, in_wdata, in_size, in_is_load, in_unsigned,
                               in_rob_idx, in_rd_tag, in_rd_is_fp};

  // circular pointers and occupancy, cleared on flush
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else if (flush) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      r_wp  <= r_wp + AW'(w_push);
      r_rp  <= r_rp + AW'(w_pop);
      r_cnt <= r_cnt + (AW+1)'(w_push) - (AW+1)'(w_pop);
    end

  // cache request registers, held stable from launch until the ack
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      {r_dc_req, r_dc_we, r_dc_addr, r_dc_wdata, r_dc_wstrb} <= '0;
    end else if (w_go_req) begin
      r_dc_req   <= 1'b1;
      r_dc_we    <= !w_h.ld;
      r_dc_addr  <= {w_h.addr[31:2], 2'b00};
      r_dc_wdata <= (w_h.size == 2'd0) ? {4{w_h.wdata[7:0]}} :
                    (w_h.size == 2'd1) ? {2{w_h.wdata[15:0]}} : w_h.wdata;
      r_dc_wstrb <= w_h.ld ? 4'b0000 :
                    (w_h.size == 2'd0) ? 4'b0001 << w_h.addr[1:0] :
                    (w_h.size == 2'd1) ? 4'b0011 << w_h.addr[1:0] : 4'b1111;
    end else if (w_done) begin
      {r_dc_req, r_dc_we, r_dc_addr, r_dc_wdata, r_dc_wstrb} <= '0;
    end

  // writeback registers, pulsed for one cycle on entry to WB
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      {r_wb_valid, r_wb_value, r_wb_rob, r_wb_tag, r_wb_fp, r_wb_exc} <= '0;
    end else if (w_pop) begin
      r_wb_valid <= 1'b1;
      r_wb_value <= (w_ack && w_h.ld) ? w_ldv : 32'h0;
      r_wb_rob   <= w_h.rob;
      r_wb_tag   <= w_h.tag;
      r_wb_fp    <= w_h.fp;
      r_wb_exc   <= w_go_exc;
    end else begin
      r_wb_valid <= 1'b0;
    end
endmodule

// File: tb/tb_lsu_queue.sv
// tb_lsu_queue: directed vector bench for lsu_queue
module tb_lsu_queue;
  logic        clk = 0, rst_n = 0, flush = 0, in_valid = 0, in_ready;
  logic [31:0] in_addr = 0, in_wdata = 0, dc_addr, dc_wdata, dc_rdata = 0, wb_value;
  logic [1:0]  in_size = 0;
  logic        in_is_load = 0, in_unsigned = 0, in_rd_is_fp = 0;
  logic [5:0]  in_rob_idx = 0, in_rd_tag = 0, wb_rob_idx, wb_dest_tag;
  logic [2:0]  occupancy;
  logic        dc_req, dc_we, dc_ack = 0, wb_valid, wb_dest_is_fp, wb_exception;
  logic [3:0]  dc_wstrb;
  int          checks = 0, errors = 0;

  lsu_queue #(.DEPTH(4), .ROB_W(6), .PREG_W(6)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_addr(in_addr), .in_wdata(in_wdata), .in_size(in_size), .in_is_load(in_is_load),
    .in_unsigned(in_unsigned), .in_rob_idx(in_rob_idx), .in_rd_tag(in_rd_tag),
    .in_rd_is_fp(in_rd_is_fp), .occupancy(occupancy), .dc_req(dc_req), .dc_we(dc_we),
    .dc_addr(dc_addr), .dc_wdata(dc_wdata), .dc_wstrb(dc_wstrb), .dc_rdata(dc_rdata),
    .dc_ack(dc_ack), .wb_valid(wb_valid), .wb_value(wb_value), .wb_rob_idx(wb_rob_idx),
    .wb_dest_tag(wb_dest_tag), .wb_dest_is_fp(wb_dest_is_fp), .wb_exception(wb_exception));

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr, wdata, rdata;
    logic [1:0]  size;
    logic        ld, uns, exc;
    logic [3:0]  strb;
    logic [31:0] daddr, dwdata, wbv;
  } vec_t;

  vec_t v [13];

  function automatic vec_t mk(logic [31:0] a, logic [31:0] wd, logic [1:0] sz, logic ld,
                              logic uns, logic exc, logic [3:0] st, logic [31:0] da,
                              logic [31:0] dwd, logic [31:0] wbv);
    mk.addr = a; mk.wdata = wd; mk.rdata = 32'h80FF_1234; mk.size = sz; mk.ld = ld;
    mk.uns = uns; mk.exc = exc; mk.strb = st; mk.daddr = da; mk.dwdata = dwd; mk.wbv = wbv;
  endfunction

  task automatic chk(string nm, logic [31:0] a, logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, a, e);
    end
  endtask

  task automatic wait_req();
    int n = 0;
    while (!dc_req && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("req_timeout", 32'(dc_req), 1);
  endtask

  task automatic drive(logic [31:0] a, logic [31:0] wd, logic [1:0] sz, logic ld, logic uns,
                       int rob);
    in_valid = 1; in_addr = a; in_wdata = wd; in_size = sz; in_is_load = ld;
    in_unsigned = uns; in_rob_idx = 6'(rob); in_rd_tag = 6'(rob + 8); in_rd_is_fp = rob[0];
  endtask

  task automatic do_vec(vec_t t, int i);
    @(negedge clk);
    drive(t.addr, t.wdata, t.size, t.ld, t.uns, i);
    @(negedge clk);
    in_valid = 0;
    chk("occ_after_enq", 32'(occupancy), 1);
    @(negedge clk);
    chk("req_latency", 32'(dc_req), 32'(!t.exc));
    chk("exc_wb_latency", 32'(wb_valid), 32'(t.exc));
    if (t.exc) begin
      chk("exc_flag", 32'(wb_exception), 1);
      chk("exc_value", wb_value, 0);
      chk("exc_rob", 32'(wb_rob_idx), 32'(i));
    end else begin
      chk("dc_we", 32'(dc_we), 32'(!t.ld));
      chk("dc_addr", dc_addr, t.daddr);
      chk("dc_wdata", dc_wdata, t.dwdata);
      chk("dc_wstrb", 32'(dc_wstrb), 32'(t.strb));
      dc_rdata = t.rdata;
      dc_ack = 1;
      @(negedge clk);
      dc_ack = 0;
      chk("wb_valid", 32'(wb_valid), 1);
      chk("wb_value", wb_value, t.wbv);
      chk("wb_exc", 32'(wb_exception), 0);
      chk("wb_rob", 32'(wb_rob_idx), 32'(i));
      chk("wb_tag", 32'(wb_dest_tag), 32'(i + 8));
      chk("wb_fp", 32'(wb_dest_is_fp), 32'(i % 2));
      chk("req_dropped", 32'(dc_req), 0);
    end
    @(negedge clk);
    chk("wb_one_cycle", 32'(wb_valid), 0);
  endtask

  initial begin
    v[0]  = mk(32'h103, 0, 0, 1, 0, 0, 4'b0000, 32'h100, 0, 32'hFFFF_FF80);
    v[1]  = mk(32'h103, 0, 0, 1, 1, 0, 4'b0000, 32'h100, 0, 32'h0000_0080);
    v[2]  = mk(32'h202, 32'hABCD, 1, 0, 0, 0, 4'b1100, 32'h200, 32'hABCD_ABCD, 0);
    v[3]  = mk(32'h101, 0, 2, 1, 0, 1, 0, 0, 0, 0);
    v[4]  = mk(32'h102, 0, 1, 1, 0, 0, 4'b0000, 32'h100, 0, 32'hFFFF_80FF);
    v[5]  = mk(32'h100, 0, 1, 1, 1, 0, 4'b0000, 32'h100, 0, 32'h0000_1234);
    v[6]  = mk(32'h104, 0, 2, 1, 1, 0, 4'b0000, 32'h104, 0, 32'h80FF_1234);
    v[7]  = mk(32'h101, 32'h1234_5678, 0, 0, 0, 0, 4'b0010, 32'h100, 32'h7878_7878, 0);
    v[8]  = mk(32'h30C, 32'hDEAD_BEEF, 2, 0, 0, 0, 4'b1111, 32'h30C, 32'hDEAD_BEEF, 0);
    v[9]  = mk(32'h000, 0, 3, 1, 0, 1, 0, 0, 0, 0);
    v[10] = mk(32'h203, 32'h5555, 1, 0, 0, 1, 0, 0, 0, 0);
    v[11] = mk(32'h102, 0, 0, 1, 0, 0, 4'b0000, 32'h100, 0, 32'hFFFF_FFFF);
    v[12] = mk(32'h100, 0, 0, 1, 0, 0, 4'b0000, 32'h100, 0, 32'h0000_0034);

    repeat (2) @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 1);
    chk("rst_occ", 32'(occupancy), 0);
    chk("rst_dc", {dc_req, dc_we, dc_wstrb}, 0);
    chk("rst_dc_addr", dc_addr, 0);
    chk("rst_dc_wdata", dc_wdata, 0);
    chk("rst_wb", {wb_valid, wb_exception, wb_dest_is_fp, wb_rob_idx, wb_dest_tag}, 0);
    chk("rst_wb_value", wb_value, 0);
    rst_n = 1;
    @(negedge clk);

    for (int i = 0; i < 13; i++) do_vec(v[i], i);

    for (int i = 0; i < 4; i++) begin
      drive(32'h400 + 32'(4 * i), 0, 2, 1, 0, i);
      @(negedge clk);
    end
    in_valid = 0;
    chk("full_occ", 32'(occupancy), 4);
    chk("full_ready", 32'(in_ready), 0);
    drive(32'h500, 0, 2, 1, 0, 7);
    @(negedge clk);
    in_valid = 0;
    chk("full_no_enq", 32'(occupancy), 4);
    for (int i = 0; i < 4; i++) begin
      wait_req();
      chk("fill_addr", dc_addr, 32'h400 + 32'(4 * i));
      dc_rdata = 32'(i) * 32'h11;
      dc_ack = 1;
      @(negedge clk);
      dc_ack = 0;
      chk("fill_wb_valid", 32'(wb_valid), 1);
      chk("fill_rob_order", 32'(wb_rob_idx), 32'(i));
      chk("fill_value", wb_value, 32'(i) * 32'h11);
    end
    @(negedge clk);
    chk("fill_drained", 32'(occupancy), 0);

    dc_ack = 1;
    @(negedge clk);
    dc_ack = 0;
    @(negedge clk);
    chk("idle_ack_ignored", {31'b0, wb_valid}, 0);

    drive(32'h500, 0, 2, 1, 0, 9);
    wait_req();
    in_valid = 0;
    flush = 1;
    @(negedge clk);
    flush = 0;
    in_valid = 1;
    chk("drain_req", 32'(dc_req), 1);
    chk("drain_ready", 32'(in_ready), 0);
    chk("drain_occ", 32'(occupancy), 0);
    chk("drain_addr", dc_addr, 32'h500);
    flush = 1;
    @(negedge clk);
    flush = 0;
    chk("drain_reflush_req", 32'(dc_req), 1);
    chk("drain_reflush_ready", 32'(in_ready), 0);
    chk("drain_no_wb", 32'(wb_valid), 0);
    @(negedge clk);
    in_valid = 0;
    dc_ack = 1;
    chk("drain_ack_ready", 32'(in_ready), 0);
    chk("drain_no_enq", 32'(occupancy), 0);
    @(negedge clk);
    dc_ack = 0;
    chk("drain_done_ready", 32'(in_ready), 1);
    chk("drain_done_req", 32'(dc_req), 0);
    chk("drain_done_wb", 32'(wb_valid), 0);
    @(negedge clk);
    chk("drain_late_wb", 32'(wb_valid), 0);
    chk("drain_final_occ", 32'(occupancy), 0);

    drive(32'h600, 0, 2, 1, 0, 3);
    flush = 1;
    @(negedge clk);
    in_valid = 0;
    flush = 0;
    chk("flush_beats_enq", 32'(occupancy), 0);
    @(negedge clk);
    chk("flush_no_req", 32'(dc_req), 0);

    drive(32'h700, 0, 2, 1, 0, 4);
    wait_req();
    in_valid = 0;
    #2 rst_n = 0;
    #1;
    chk("async_rst_req", 32'(dc_req), 0);
    chk("async_rst_occ", 32'(occupancy), 0);
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    chk("post_rst_ready", 32'(in_ready), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
